// File: rtl/fifo_uart_pkg.sv
// rtl/fifo_uart_pkg.sv - state encoding and counter-width helper shared by the fifo_uart_tx slice
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } uart_state_t;

  // A counter for n states needs at least one bit even when n is 1.
  function automatic int ctr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - free-running bit-period tick, realigned by restart
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_done
);
  import fifo_uart_pkg::*;

  localparam int TW = ctr_width(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] tick;

  // Wrapping at LAST is the reload at every bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick <= '0;
    end else if (restart || tick == LAST) begin
      tick <= '0;
    end else begin
      tick <= tick + 1'b1;
    end
  end

  assign bit_done = (tick == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - drains a synchronous FIFO one word per serial frame (start, LSB-first data, stop)
module fifo_uart_tx #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_r_en,
  output logic              tx,
  output logic              busy
);
  import fifo_uart_pkg::*;

  localparam int BW = ctr_width(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  uart_state_t       state;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bit_cnt;
  logic              bit_done;
  logic              restart;
  logic              can_pop;

  assign can_pop = tx_enable && !fifo_empty;
  assign restart = (state == ST_LOAD);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .bit_done(bit_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      tx        <= 1'b1;
      fifo_r_en <= 1'b0;
      busy      <= 1'b0;
    end else begin
      fifo_r_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (can_pop) begin
            state     <= ST_POP;
            fifo_r_en <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_POP: state <= ST_LOAD;
        // FIFO data_out is valid here, one cycle after the read strobe.
        ST_LOAD: begin
          shreg <= fifo_data;
          tx    <= 1'b0;
          state <= ST_START;
        end
        ST_START: begin
          if (bit_done) begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            if (bit_cnt == LAST_BIT) begin
              tx    <= 1'b1;
              state <= ST_STOP;
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            if (can_pop) begin
              state     <= ST_POP;
              fifo_r_en <= 1'b1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
